seg_pipe_adder: RTL and testbench

SEG_PIPE_ADDER -- requirements
Module: seg_pipe_adder

---
 rtl/seg_pipe_adder_pkg.sv | 29 ++
 rtl/seg_pipe_adder_if.sv | 37 +++
 rtl/seg_adder.sv | 23 ++
 rtl/seg_pipe_adder.sv | 183 ++++++++++++++++++
 tb/tb_seg_pipe_adder.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pipe_adder_pkg.sv
// ============================================================================
// Module   : seg_pipe_adder_pkg
// Purpose  : Shared types and constants for the segmented pipelined adder:
//            FSM state encoding, mode encoding and segment-count helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pipe_adder_pkg;

  // Controller states; explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // mode_i encoding
  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT  = 1'b1;

  // Number of segments an operand is split into
  function automatic int calc_nseg(input int width, input int segment);
    return width / segment;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_pipe_adder_if.sv
// ============================================================================
// Module   : seg_pipe_adder_if
// Purpose  : Handshake/operand bundle for seg_pipe_adder. The master drives
//            operands and consumes results; the slave is the adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_pipe_adder_if #(
  parameter int WIDTH = 32
) (
  input logic clk
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] add1;
  logic [WIDTH-1:0] add2;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             err;

  modport master (
    input  clk, in_ready, out_valid, result, err,
    output in_valid, add1, add2, mode, out_ready
  );

  modport slave (
    input  clk, in_valid, add1, add2, mode, out_ready,
    output in_ready, out_valid, result, err
  );

endinterface

`default_nettype wire

// File: rtl/seg_adder.sv
// ============================================================================
// Module   : seg_adder
// Purpose  : Plain SEGMENT-bit ripple adder with carry in and carry out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_adder #(
  parameter int SEGMENT = 8
) (
  input  logic [SEGMENT-1:0] a,
  input  logic [SEGMENT-1:0] b,
  input  logic               cin,
  output logic [SEGMENT-1:0] sum,
  output logic               cout
);

  // One extra bit of headroom captures the carry out
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEGMENT{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/seg_pipe_adder.sv
// ============================================================================
// Module   : seg_pipe_adder
// Purpose  : Segmented adder with two modes. Approximate mode adds all
//            segments in parallel with carry-in 0 (one cycle). Exact mode
//            walks the segments LSB first, feeding the registered carry into
//            the active segment (NSEG cycles).
// Config   : SEG_PIPE_ADDER_ERR_DETECT_EN - when defined, err_o flags an
//            approximate result whose dropped inner carries made it differ
//            from the exact sum. Undefined: err_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_pipe_adder
  import seg_pipe_adder_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SEGMENT = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic             mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o,
  output logic             err_o
);

  localparam int NSEG  = calc_nseg(WIDTH, SEGMENT);
  localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NSEG - 1);

  if ((WIDTH % SEGMENT) != 0) begin : g_bad_width
    $error("seg_pipe_adder: WIDTH must be a multiple of SEGMENT");
  end

  state_e             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_add1;
  logic [WIDTH-1:0]   r_add2;
  logic               r_mode;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH:0]     r_result;

  logic [SEGMENT-1:0] w_sum [NSEG];
  logic [NSEG-1:0]    w_cout;
  logic [NSEG-1:0]    w_cin;
  logic [WIDTH-1:0]   w_approx_sum;
  logic [WIDTH-1:0]   w_acc_next;
  logic               w_sel_cout;
  logic               w_approx_done;
  logic               w_exact_done;

  // Segment adders shared by both modes; only the active exact-mode segment
  // sees the running carry, every other carry-in stays 0
  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    assign w_cin[k] = (r_mode == MODE_EXACT) && (r_idx == IDX_W'(k)) ? r_carry : 1'b0;

    seg_adder #(.SEGMENT(SEGMENT)) u_seg (
      .a    (r_add1[k*SEGMENT +: SEGMENT]),
      .b    (r_add2[k*SEGMENT +: SEGMENT]),
      .cin  (w_cin[k]),
      .sum  (w_sum[k]),
      .cout (w_cout[k])
    );

    assign w_approx_sum[k*SEGMENT +: SEGMENT] = w_sum[k];
  end

  // Merge the active segment's sum into the exact accumulator and pick its carry
  always_comb begin
    w_acc_next = r_acc;
    w_sel_cout = 1'b0;
    for (int k = 0; k < NSEG; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_acc_next[k*SEGMENT +: SEGMENT] = w_sum[k];
        w_sel_cout                       = w_cout[k];
      end
    end
  end

  assign w_approx_done = (r_state == ST_CALC) && (r_mode == MODE_APPROX);
  assign w_exact_done  = (r_state == ST_CALC) && (r_mode == MODE_EXACT) && (r_idx == C_LAST_IDX);

  // Control FSM with registered handshake flags and result register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_add1      <= '0;
      r_add2      <= '0;
      r_mode      <= MODE_APPROX;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_acc       <= '0;
      r_result    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_add1     <= add1_i;
            r_add2     <= add2_i;
            r_mode     <= mode_i;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (w_approx_done) begin
            r_result    <= {w_cout[NSEG-1], w_approx_sum};
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_acc   <= w_acc_next;
            r_carry <= w_sel_cout;
            if (w_exact_done) begin
              r_result    <= {w_sel_cout, w_acc_next};
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SEG_PIPE_ADDER_ERR_DETECT_EN
  logic w_approx_err;
  logic r_err;

  if (NSEG > 1) begin : g_err_multi
    assign w_approx_err = |w_cout[NSEG-2:0];
  end else begin : g_err_single
    assign w_approx_err = 1'b0;
  end

  // Error flag is written together with the result on entry to DONE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_approx_done) begin
      r_err <= w_approx_err;
    end else if (w_exact_done) begin
      r_err <= 1'b0;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign result_o    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_seg_pipe_adder.sv
// ============================================================================
// Module   : tb_seg_pipe_adder
// Purpose  : Self-checking bench for seg_pipe_adder (32/8 and 16/4 builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_pipe_adder;
  import seg_pipe_adder_pkg::*;

  localparam int W  = 32;
  localparam int S  = 8;
  localparam int NS = W / S;

  typedef struct {
    logic [W:0] res;
    logic       err;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seg_pipe_adder_if #(.WIDTH(W)) bus (.clk(clk));

  seg_pipe_adder #(.WIDTH(W), .SEGMENT(S)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .add1_i      (bus.add1),
    .add2_i      (bus.add2),
    .mode_i      (bus.mode),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .result_o    (bus.result),
    .err_o       (bus.err)
  );

  logic        v16, rdy16, m16, ov16, or16, err16;
  logic [15:0] a16, b16;
  logic [16:0] res16;

  seg_pipe_adder #(.WIDTH(16), .SEGMENT(4)) dut16 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (v16),
    .in_ready_o  (rdy16),
    .add1_i      (a16),
    .add2_i      (b16),
    .mode_i      (m16),
    .out_valid_o (ov16),
    .out_ready_i (or16),
    .result_o    (res16),
    .err_o       (err16)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stall_n  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact = plain wide addition; approximate = each segment
  // summed on its own, inner carries lost, top carry kept as the MSB
  function automatic void ref_add(input longint unsigned a, input longint unsigned b,
                                  input int w, input int s, input logic m,
                                  output longint unsigned r, output logic e);
    longint unsigned mask = (64'd1 << s) - 1;
    longint unsigned part;
    logic lost = 1'b0;
    if (m == MODE_EXACT) begin
      r = a + b;
    end else begin
      r = 0;
      for (int k = 0; k < w / s; k++) begin
        part = ((a >> (k * s)) & mask) + ((b >> (k * s)) & mask);
        r = r | ((part & mask) << (k * s));
        if (part > mask) begin
          if (k == w / s - 1) r = r | (64'd1 << w);
          else                lost = 1'b1;
        end
      end
    end
`ifdef SEG_PIPE_ADDER_ERR_DETECT_EN
    e = (m == MODE_APPROX) ? lost : 1'b0;
`else
    e = 1'b0;
`endif
  endfunction

  // Drive junk (ignored) while busy; push the expectation at acceptance
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    exp_t e;
    longint unsigned r;
    logic er;
    int guard = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        bus.in_valid = 1'b1;
        bus.add1 = a;
        bus.add2 = b;
        bus.mode = m;
        ref_add(longint'(a), longint'(b), W, S, m, r, er);
        e.res = r[W:0];
        e.err = er;
        e.cyc = cyc + 1 + ((m == MODE_EXACT) ? NS : 1);
        sb.push_back(e);
        done = 1;
      end else begin
        bus.in_valid = ~bus.in_valid;
        bus.add1 = $urandom;
        bus.add2 = $urandom;
        bus.mode = 1'($urandom_range(0, 1));
        guard++;
        if (guard > 500) begin
          chk("issue_timeout", 64'd0, 64'd1);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || bus.out_valid) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  // Monitor/consumer: compare on first presentation, then check stability
  initial begin
    exp_t cur;
    bit presented = 0;
    bit released = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && released) begin
        chk("idle_after_release_ready", 64'(bus.in_ready), 64'd1);
        chk("idle_after_release_valid", 64'(bus.out_valid), 64'd0);
      end
      released = 0;
      if (rst_n && bus.out_valid) begin
        if (!presented) begin
          presented = 1;
          if (sb.size() == 0) begin
            chk("unexpected_output", 64'(bus.result), 64'd0 - 64'd1);
            cur.res = bus.result;
            cur.err = bus.err;
          end else begin
            cur = sb.pop_front();
            chk("result", 64'(bus.result), 64'(cur.res));
            chk("err", 64'(bus.err), 64'(cur.err));
            chk("latency", 64'(cyc), 64'(cur.cyc));
          end
        end else begin
          chk("hold_result", 64'(bus.result), 64'(cur.res));
          chk("hold_err", 64'(bus.err), 64'(cur.err));
        end
        chk("in_ready_in_done", 64'(bus.in_ready), 64'd0);
        if (stall_n > 0) begin
          stall_n--;
          bus.out_ready = 1'b0;
        end else begin
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        if (bus.out_ready) begin
          presented = 0;
          released = 1;
        end
      end else begin
        presented = 0;
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic m);
    longint unsigned r;
    logic er;
    int lat = 0;
    ref_add(longint'(a), longint'(b), 16, 4, m, r, er);
    @(negedge clk);
    chk("dut16_ready", 64'(rdy16), 64'd1);
    v16 = 1'b1; a16 = a; b16 = b; m16 = m;
    @(posedge clk);
    #1 v16 = 1'b0;
    while (!ov16 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("dut16_latency", 64'(lat), (m == MODE_EXACT) ? 64'd4 : 64'd1);
    chk("dut16_result", 64'(res16), 64'(r[16:0]));
    chk("dut16_err", 64'(err16), 64'(er));
    or16 = 1'b1;
    @(posedge clk);
    #1 or16 = 1'b0;
    chk("dut16_idle_valid", 64'(ov16), 64'd0);
  endtask

  initial begin
    logic [W-1:0] a, b;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.add1 = '0; bus.add2 = '0; bus.mode = MODE_APPROX;
    v16 = 1'b0; a16 = '0; b16 = '0; m16 = MODE_APPROX; or16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", 64'(bus.result), 64'd0);
    chk("reset_err", 64'(bus.err), 64'd0);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed corner operands
    issue(32'h000000FF, 32'h00000001, MODE_APPROX);
    issue(32'h000000FF, 32'h00000001, MODE_EXACT);
    issue(32'hFFFFFFFF, 32'h00000001, MODE_EXACT);
    issue(32'hFFFFFFFF, 32'h00000001, MODE_APPROX);
    drain();

    // Held result under back-pressure with in_valid pulsing
    stall_n = 5;
    issue(32'h80FF7F01, 32'h7F01FFFF, MODE_APPROX);
    issue(32'h00010002, 32'h00030004, MODE_EXACT);
    drain();

    // Randomised traffic with carry-heavy patterns
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'hFFFFFFFF ^ (32'd1 << $urandom_range(0, 31)); b = 32'($urandom_range(0, 3)); end
        default: begin a = {8'($urandom), 8'hFF, 8'($urandom), 8'hFF}; b = 32'h00010001; end
      endcase
      issue(a, b, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Asynchronous reset in the middle of an exact operation
    issue(32'hDEADBEEF, 32'h00000001, MODE_EXACT);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_result", 64'(bus.result), 64'd0);
    chk("async_rst_err", 64'(bus.err), 64'd0);
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    issue(32'h12345678, 32'h11111111, MODE_EXACT);
    drain();

    // Narrow build: 16-bit operands, 4-bit segments
    run16(16'h0FFF, 16'h0001, MODE_EXACT);
    run16(16'h0FFF, 16'h0001, MODE_APPROX);
    run16(16'hFFFF, 16'h0001, MODE_EXACT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
